gate_arbiter: RTL

GATE_ARBITER -- requirements
Module: gate_arbiter

---
 rtl/gate_arbiter_pkg.sv | 12 +
 rtl/gate_arbiter_rr_pick.sv | 24 ++
 rtl/gate_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gate_arbiter_pkg.sv
// Shared parking-controller types: arbiter FSM encoding and the default
// starvation limit.
package gate_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    SETTLE = 1'b1
  } arb_state_e;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/gate_arbiter_rr_pick.sv
// Round-robin picker: returns the first requesting gate at or after ptr_i,
// wrapping past the last gate.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && req_i[(int'(ptr_i) + k) % N]) begin
        valid_o = 1'b1;
        idx_o   = PW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/gate_arbiter.sv
// Gate arbiter: grants one entry or exit gate per two cycles and reports
// accepted cars to the parking counter.
//   state  | meaning
//   ARB    | pick a winner among pending requests, register its pulses
//   SETTLE | pulses visible for one cycle, requests ignored
module gate_arbiter
  import gate_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int NGATE        = 2
) (
  input  logic             CLK,
  input  logic             Start_n,
  input  logic [NGATE-1:0] ent_req,
  input  logic [NGATE-1:0] ent_uni,
  input  logic [NGATE-1:0] ext_req,
  input  logic [NGATE-1:0] ext_uni,
  input  logic             uni_is_vacated_space,
  input  logic             is_vacated_space,
  input  logic [9:0]       uni_parked_car,
  input  logic [9:0]       parked_car,
  output logic [NGATE-1:0] ent_ack,
  output logic [NGATE-1:0] ext_ack,
  output logic [NGATE-1:0] ent_accept,
  output logic [NGATE-1:0] ext_accept,
  output logic             car_entered,
  output logic             is_uni_car_entered,
  output logic             car_exited,
  output logic             is_uni_car_exited,
  output logic             busy
);

  localparam int PW = (NGATE > 1) ? $clog2(NGATE) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  arb_state_e       state_q;
  logic [PW-1:0]    ent_ptr_q, ext_ptr_q, ent_ptr_d, ext_ptr_d;
  logic [SW-1:0]    starve_q;
  logic [NGATE-1:0] ent_ack_q, ent_acc_q, ext_ack_q, ext_acc_q;
  logic             car_ent_q, uni_ent_q, car_ext_q, uni_ext_q, busy_q;

  logic             ent_valid, ext_valid;
  logic [PW-1:0]    ent_idx, ext_idx;
  logic [NGATE-1:0] ent_hot, ext_hot;
  logic             ent_ok, ext_ok, starve_hit, serve_ent, serve_ext;

  rr_pick #(.N(NGATE), .PW(PW)) u_ent_pick (
    .req_i   (ent_req),
    .ptr_i   (ent_ptr_q),
    .valid_o (ent_valid),
    .idx_o   (ent_idx)
  );

  rr_pick #(.N(NGATE), .PW(PW)) u_ext_pick (
    .req_i   (ext_req),
    .ptr_i   (ext_ptr_q),
    .valid_o (ext_valid),
    .idx_o   (ext_idx)
  );

  // Verdicts only test vacancy flags and zero counts; the counter owns arithmetic.
  always_comb begin
    starve_hit = (starve_q == SW'(STARVE_LIMIT));
    serve_ent  = ent_valid && (!ext_valid || starve_hit);
    serve_ext  = ext_valid && !serve_ent;
    ent_hot    = NGATE'(1) << ent_idx;
    ext_hot    = NGATE'(1) << ext_idx;
    ent_ok     = ent_uni[ent_idx] ? uni_is_vacated_space : is_vacated_space;
    ext_ok     = ext_uni[ext_idx] ? (uni_parked_car != 10'd0) : (parked_car != 10'd0);
    ent_ptr_d  = (ent_idx == PW'(NGATE - 1)) ? '0 : ent_idx + PW'(1);
    ext_ptr_d  = (ext_idx == PW'(NGATE - 1)) ? '0 : ext_idx + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!Start_n) begin
      state_q   <= ARB;
      ent_ptr_q <= '0;
      ext_ptr_q <= '0;
      starve_q  <= '0;
      ent_ack_q <= '0;
      ent_acc_q <= '0;
      ext_ack_q <= '0;
      ext_acc_q <= '0;
      car_ent_q <= 1'b0;
      uni_ent_q <= 1'b0;
      car_ext_q <= 1'b0;
      uni_ext_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // Pulses default low so they last exactly the SETTLE cycle.
      ent_ack_q <= '0;
      ent_acc_q <= '0;
      ext_ack_q <= '0;
      ext_acc_q <= '0;
      car_ent_q <= 1'b0;
      uni_ent_q <= 1'b0;
      car_ext_q <= 1'b0;
      uni_ext_q <= 1'b0;
      busy_q    <= 1'b0;
      case (state_q)
        ARB: begin
          if (serve_ent) begin
            state_q   <= SETTLE;
            busy_q    <= 1'b1;
            ent_ack_q <= ent_hot;
            ent_acc_q <= ent_ok ? ent_hot : '0;
            car_ent_q <= ent_ok;
            uni_ent_q <= ent_ok & ent_uni[ent_idx];
            ent_ptr_q <= ent_ptr_d;
            starve_q  <= '0;
          end else if (serve_ext) begin
            state_q   <= SETTLE;
            busy_q    <= 1'b1;
            ext_ack_q <= ext_hot;
            ext_acc_q <= ext_ok ? ext_hot : '0;
            car_ext_q <= ext_ok;
            uni_ext_q <= ext_ok & ext_uni[ext_idx];
            ext_ptr_q <= ext_ptr_d;
            if (ent_valid && !starve_hit) starve_q <= starve_q + SW'(1);
          end
        end
        SETTLE: state_q <= ARB;
      endcase
    end
  end

  assign ent_ack            = ent_ack_q;
  assign ent_accept         = ent_acc_q;
  assign ext_ack            = ext_ack_q;
  assign ext_accept         = ext_acc_q;
  assign car_entered        = car_ent_q;
  assign is_uni_car_entered = uni_ent_q;
  assign car_exited         = car_ext_q;
  assign is_uni_car_exited  = uni_ext_q;
  assign busy               = busy_q;

endmodule
